// File: rtl/parallel_in_pkg.sv
// Shared constants for the parallel input port: default bus addresses,
// status word bit positions and a helper that packs the status word.
package parallel_in_pkg;

    localparam logic [31:0] DEF_ADDR_CH0  = 32'h0000_00FF;
    localparam logic [31:0] DEF_ADDR_CH1  = 32'h0000_00FE;
    localparam logic [31:0] DEF_ADDR_STAT = 32'h0000_00FD;

    localparam int READY0 = 0;
    localparam int READY1 = 1;
    localparam int OVR0   = 2;
    localparam int OVR1   = 3;

    // Builds the status word from the per-channel flags.
    function automatic logic [31:0] status_word(input logic ready0, input logic ready1,
                                                input logic ovr0,   input logic ovr1);
        logic [31:0] w;
        w         = '0;
        w[READY0] = ready0;
        w[READY1] = ready1;
        w[OVR0]   = ovr0;
        w[OVR1]   = ovr1;
        return w;
    endfunction

endpackage

// File: rtl/parallel_in_if.sv
// CPU read bus of the parallel input port: enable and address from the CPU,
// registered read data and valid flag back to it.
interface parallel_in_if;

    logic        EN;
    logic [31:0] Address;
    logic [31:0] ReadData;
    logic        Valid;

    modport master (output EN, output Address, input  ReadData, input  Valid);
    modport slave  (input  EN, input  Address, output ReadData, output Valid);

endinterface

// File: rtl/pin_channel.sv
// One input channel: strobe synchroniser and rising-edge detector, holding
// register for the captured word, and ready/overrun flags cleared by a read.
module pin_channel (
    input  logic        clk,
    input  logic        rst,
    input  logic        strobe,
    input  logic [31:0] data_in,
    input  logic        rd_clr,
    output logic [31:0] data,
    output logic        ready,
    output logic        overrun
);

    logic s1, s2, s3;
    logic rise;

    assign rise = s2 & ~s3;

    // Two-flop synchroniser for the asynchronous strobe plus a history flop.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= strobe;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Holding register loads the external word on a detected strobe rise.
    // NOTE: this storage is reset because software may read it before any
    // capture and must see zero, not X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else if (rise) begin
            data <= data_in;
        end
    end

    // Ready/overrun flags: a capture beats a same-edge read clear, and a
    // capture over unread data is an overrun unless that data is read now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (rise) begin
                ready <= 1'b1;
            end else if (rd_clr) begin
                ready <= 1'b0;
            end

            if (rise && ready && !rd_clr) begin
                overrun <= 1'b1;
            end else if (rd_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/parallel_in.sv
// Memory-mapped parallel input port: two strobed 32-bit channels, address
// decoded reads with one cycle of latency, and an interrupt on pending data.
module parallel_in
    import parallel_in_pkg::*;
#(
    parameter logic [31:0] ADDR_CH0  = DEF_ADDR_CH0,
    parameter logic [31:0] ADDR_CH1  = DEF_ADDR_CH1,
    parameter logic [31:0] ADDR_STAT = DEF_ADDR_STAT
) (
    input  logic                clk,
    input  logic                rst,
    parallel_in_if.slave        bus,
    input  logic [31:0]         DataIn1,
    input  logic [31:0]         DataIn2,
    input  logic                Strobe1,
    input  logic                Strobe2,
    output logic                IRQ
);

    logic [31:0] data0, data1;
    logic        ready0, ready1;
    logic        ovr0, ovr1;
    logic        hit0, hit1, hit_stat;
    logic [31:0] rd_mux;

    pin_channel u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .strobe  (Strobe1),
        .data_in (DataIn1),
        .rd_clr  (hit0),
        .data    (data0),
        .ready   (ready0),
        .overrun (ovr0)
    );

    pin_channel u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .strobe  (Strobe2),
        .data_in (DataIn2),
        .rd_clr  (hit1),
        .data    (data1),
        .ready   (ready1),
        .overrun (ovr1)
    );

    // Address decode and read-data selection; unmapped addresses return zero.
    // NOTE: every output of this block gets a default first so no latch forms.
    always_comb begin
        hit0     = 1'b0;
        hit1     = 1'b0;
        hit_stat = 1'b0;
        rd_mux   = '0;
        if (bus.EN) begin
            if (bus.Address == ADDR_CH0) begin
                hit0   = 1'b1;
                rd_mux = data0;
            end else if (bus.Address == ADDR_CH1) begin
                hit1   = 1'b1;
                rd_mux = data1;
            end else if (bus.Address == ADDR_STAT) begin
                hit_stat = 1'b1;
                rd_mux   = status_word(ready0, ready1, ovr0, ovr1);
            end
        end
    end

    // Registered read port: updates only on enabled cycles, Valid pulses once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ReadData <= '0;
            bus.Valid    <= 1'b0;
        end else if (bus.EN) begin
            bus.ReadData <= rd_mux;
            bus.Valid    <= hit0 | hit1 | hit_stat;
        end else begin
            bus.Valid    <= 1'b0;
        end
    end

    assign IRQ = ready0 | ready1;

endmodule

// File: doc/parallel_in.md
# parallel_in

Memory-mapped parallel input port: the read-side counterpart of the parallel output port on the same CPU data bus. Two external 32-bit channels, each qualified by an asynchronous strobe, are synchronised, edge-detected and captured into holding registers with ready/overrun flags. The CPU reads the captured words and a status word through address-decoded reads with one cycle of latency. An interrupt line flags pending data.

## Interface
Parameters:
- ADDR_CH0, 32'h000000FF, data address of channel 0
- ADDR_CH1, 32'h000000FE, data address of channel 1
- ADDR_STAT, 32'h000000FD, status address

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- EN  in  1  read enable from CPU bus
- Address  in  32  bus address
- DataIn1  in  32  channel 0 external data, asynchronous
- DataIn2  in  32  channel 1 external data, asynchronous
- Strobe1  in  1  channel 0 capture strobe, asynchronous, rising-edge active
- Strobe2  in  1  channel 1 capture strobe, asynchronous, rising-edge active
- ReadData  out  32  registered read data
- Valid  out  1  registered; high for one cycle after a mapped read
- IRQ  out  1  ready0 OR ready1

## Operation
- Reset (rst=0, asynchronous): all state cleared. Holding registers, ready/overrun flags, synchroniser flops, ReadData=0, Valid=0, IRQ=0.
- Per channel: Strobe passes through a 2-flop synchroniser (s1, s2), plus a history flop s3. rise = s2 & ~s3.
- Capture: on rise, the holding register loads DataIn at the next edge and ready is set.
- Overrun: if a capture occurs while ready=1 and the same edge has no data read of that channel, overrun is set. Newest data overwrites the old data.
- Read decode at each edge when EN=1:
  - Address==ADDR_CH0: ReadData takes holding0. ready0 and overrun0 clear.
  - Address==ADDR_CH1: ReadData takes holding1. ready1 and overrun1 clear.
  - Address==ADDR_STAT: ReadData = {28'b0, overrun1, overrun0, ready1, ready0}. No flags clear.
  - Any mapped address: Valid=1 for the next cycle.
  - Unmapped address: ReadData=0, Valid=0.
- EN=0: ReadData holds its value and Valid=0.
- Simultaneous capture and data read on the same channel at the same edge:
  - ReadData returns the old holding value.
  - The holding register loads the new value.
  - ready stays 1; overrun stays 0.
- A status read coinciding with a capture returns the pre-edge flags.
- Both channels are fully independent. Captures on both channels in the same cycle are both honoured.

## Timing
- Strobe rise sampled by s1 at edge k:
  - s2=1 at k+1.
  - Capture and ready=1 at k+2.
  - IRQ high after k+2.
- External data must be stable from edge k through k+2.
- Strobe high and low times must each be ≥2 clk. Shorter pulses may be lost, and that loss is not flagged.
- Read latency is 1 cycle: EN/Address sampled at edge n; ReadData and Valid are valid after n until edge n+1.
- Back-to-back reads on consecutive cycles are permitted.
- Flag clear on read takes effect at edge n. A status read at n+1 shows the cleared flags.
- rst asserted mid-capture (between k and k+2) aborts the capture. The synchroniser restarts from 0. A strobe still high after reset release produces a rise and a capture.

## Structure
- Shared package: the three default addresses and the status-bit positions (READY0=0, READY1=1, OVR0=2, OVR1=3).
- Sub-module `pin_channel`, instantiated twice. It contains:
  - the synchroniser, edge detector and holding register;
  - the ready/overrun flags.
  - Inputs: clk, rst, strobe, data_in, rd_clr. Outputs: data, ready, overrun.
- The top level holds the address decode, the ReadData/Valid registers and the IRQ OR.

## Test plan
- Reset: hold rst=0 with strobes toggling → ReadData=0, Valid=0, IRQ=0. Status read after release returns 0.
- Single capture: DataIn1=32'hDEADBEEF, Strobe1 rises at edge k → ready0=1 and IRQ=1 at k+2. Read at 0xFF → ReadData=32'hDEADBEEF and Valid=1 next cycle; IRQ=0 afterwards.
- Overrun: two Strobe2 rises with 32'h1 then 32'h2 and no read → status read=32'h0000000A. Read at 0xFE returns 32'h2. Status then reads 0.
- Collision: read 0xFF at the same edge channel 0 captures 32'h55 over old 32'h44 → ReadData=32'h44, ready0 stays 1, overrun0=0. Next read returns 32'h55.
- Decode: EN=1 with Address=32'h100 → ReadData=0, Valid=0. EN=0 → ReadData holds its previous value.
- Reset mid-capture: Strobe1 rises, rst pulses low at k+1 while Strobe1 stays high → one capture after release, ready0=1, overrun0=0.
